// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, dif = a - b - bin (mod 2^WIDTH), with
// borrow-out. One bit is resolved per clock, LSB first, so an operation takes
// WIDTH cycles in RUN plus one cycle in DONE.
//
// Ports
//   clk    in   single clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   begin an operation (only honoured in IDLE)
//   a      in   minuend, captured on the accepted start edge
//   b      in   subtrahend, captured on the accepted start edge
//   bin    in   borrow-in, captured on the accepted start edge
//   dif    out  registered difference, holds the last completed result
//   bout   out  registered borrow-out of the last completed result
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse in DONE, dif/bout valid for the new result
//
// State table
//   state  | meaning
//   IDLE   | waiting for start; busy=0, done=0
//   RUN    | one subtractor bit per cycle, cnt = bit index being processed
//   DONE   | result just published; done=1 for this single cycle

module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] dif,
   output logic             bout,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   // Shadow result: collects difference bits while running so that dif never
   // shows a partially computed value.
   logic [WIDTH-2:0] res;
   logic [CW-1:0]    cnt;
   logic             br;

   logic             x;
   logic             y;
   logic             d;
   logic             br_nxt;
   logic             last;
   logic             load;
   logic             step;
   // New bit at the top, older bits below; its upper WIDTH-1 bits are the
   // right-shifted shadow, and the whole vector is the finished result on the
   // last bit.
   logic [WIDTH-1:0] res_cat;

   assign x       = sh_a[0];
   assign y       = sh_b[0];
   assign d       = x ^ y ^ br;
   assign br_nxt  = (~x & y) | (~(x ^ y) & br);
   assign last    = (cnt == CNT_LAST);
   assign res_cat = {d, res};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (last) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_a <= '0;
         sh_b <= '0;
         res  <= '0;
         cnt  <= '0;
         br   <= 1'b0;
         dif  <= '0;
         bout <= 1'b0;
      end else if (load) begin
         sh_a <= a;
         sh_b <= b;
         br   <= bin;
         cnt  <= '0;
      end else if (step) begin
         sh_a <= sh_a >> 1;
         sh_b <= sh_b >> 1;
         res  <= res_cat[WIDTH-1:1];
         br   <= br_nxt;
         if (last) begin
            cnt  <= '0;
            dif  <= res_cat;
            bout <= br_nxt;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand and difference width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  minuend, captured on the accepted start edge.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend, captured on the accepted start edge.
REQ-007 SHALL have port: bin  input  1  borrow-in for chaining, captured on the accepted start edge.
REQ-008 SHALL have port: dif  output  WIDTH  registered difference a-b-bin modulo 2^WIDTH.
REQ-009 SHALL have port: bout  output  1  registered final borrow-out (1 when a < b+bin, unsigned).
REQ-010 SHALL have port: busy  output  1  high while an operation is in progress (states RUN and DONE).
REQ-011 SHALL have port: done  output  1  single-cycle pulse marking dif/bout valid for the new result.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE with start=1 at edge k, load a and b into shift registers, load bin into the borrow flop, clear the bit counter, and enter RUN.
REQ-014 SHALL process one bit per cycle LSB-first in RUN, using a 1-bit full-subtractor cell: d = x^y^br; br_next = (~x&y) | (~(x^y)&br).
REQ-015 SHALL shift each d into the MSB of the result register, with the result right-shifting, so that after WIDTH bits dif[0] holds bit 0.
REQ-016 SHALL update the borrow flop with br_next every RUN cycle, and the counter SHALL increment 0..WIDTH-1.
REQ-017 SHALL leave RUN at the edge that processes bit WIDTH-1 (edge k+WIDTH), entering DONE and loading bout from the final br_next.
REQ-018 SHALL assert done=1 for exactly one cycle while in DONE (the cycle after edge k+WIDTH), then return to IDLE.
REQ-019 SHALL keep dif and bout unchanged outside of result updates: they hold the last completed result through IDLE until the next operation's DONE.
REQ-020 SHALL NOT expose partial results: dif and bout update only at the RUN->DONE transition, via a separate shadow result register.
REQ-021 SHALL ignore start when in RUN or DONE, with no effect on operands, counter or timing.
REQ-022 SHALL ignore changes on a, b and bin after capture until the next accepted start.
REQ-023 SHALL hold busy=0 and done=0 in IDLE.
REQ-024 SHALL give a back-to-back start (high in the first IDLE cycle after DONE) a start-to-start period of WIDTH+2 cycles.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, force state=IDLE, dif=0, bout=0, busy=0, done=0, counter=0 and borrow flop=0.
REQ-026 SHALL let rst take priority over start and over any state, including mid-RUN; the aborted operation SHALL produce no done pulse and no dif update.
REQ-027 SHALL accept start in the first cycle after rst deasserts.

Verification (WIDTH=8)
REQ-028 SHALL cover: a=0x05, b=0x03, bin=0, start at edge k -> done=1 in the cycle after edge k+8, dif=0x02, bout=0, busy high for 9 cycles.
REQ-029 SHALL cover: a=0x03, b=0x05, bin=0 -> dif=0xFE, bout=1.
REQ-030 SHALL cover: a=0xFF, b=0xFF, bin=1 -> dif=0xFF, bout=1; and a=0x00, b=0x00, bin=0 -> dif=0x00, bout=0.
REQ-031 SHALL cover: start pulsed again 3 cycles into RUN with different operands -> ignored; first result still delivered at the original done time.
REQ-032 SHALL cover: rst asserted 4 cycles into RUN -> next cycle busy=0, dif=0x00, bout=0, and no done pulse; then a new start with 0x10-0x01 -> dif=0x0F, bout=0.
REQ-033 SHALL cover: random a, b, bin over at least 1000 back-to-back operations -> {bout,dif} equals (a-b-bin) mod 2^9 on every done, with a WIDTH+2 start-to-start period.
